// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-to-decode and decode-to-rename bundle signals
interface decode_stage_if #(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int SEQ_W = 8
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [32*LANES-1:0]   in_instr;
    logic [LANES-1:0]      in_lane_valid;
    logic [XLEN-1:0]       in_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES-1:0]      out_lane_valid;
    logic [7*LANES-1:0]    out_opcode;
    logic [3*LANES-1:0]    out_funct3;
    logic [7*LANES-1:0]    out_funct7;
    logic [5*LANES-1:0]    out_rs1;
    logic [5*LANES-1:0]    out_rs2;
    logic [5*LANES-1:0]    out_rd;
    logic [XLEN*LANES-1:0] out_imm;
    logic [XLEN*LANES-1:0] out_pc;
    logic [LANES-1:0]      out_use_rs1;
    logic [LANES-1:0]      out_use_rs2;
    logic [LANES-1:0]      out_we_rd;
    logic [LANES-1:0]      out_illegal;
    logic [SEQ_W-1:0]      out_seq;

    modport slave (
        input  flush, in_valid, in_instr, in_lane_valid, in_pc, out_ready,
        output in_ready, out_valid, out_lane_valid, out_opcode, out_funct3, out_funct7,
               out_rs1, out_rs2, out_rd, out_imm, out_pc,
               out_use_rs1, out_use_rs2, out_we_rd, out_illegal, out_seq
    );

    modport master (
        output flush, in_valid, in_instr, in_lane_valid, in_pc, out_ready,
        input  in_ready, out_valid, out_lane_valid, out_opcode, out_funct3, out_funct7,
               out_rs1, out_rs2, out_rd, out_imm, out_pc,
               out_use_rs1, out_use_rs2, out_we_rd, out_illegal, out_seq
    );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - multi-lane RV32 field/immediate decode with one skid-free pipeline register
module decode_stage #(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int SEQ_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    decode_stage_if.slave  bus
);
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            use_rs1;
        logic            use_rs2;
        logic            we_rd;
        logic            illegal;
    } lane_t;

    function automatic lane_t decode_lane(input logic [31:0] ins);
        lane_t       r;
        logic [31:0] imm32;
        logic        legal;
        r     = '0;
        imm32 = '0;
        legal = 1'b1;
        case (ins[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM:
                imm32 = {{20{ins[31]}}, ins[31:20]};
            OPC_STORE:  imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OPC_BRANCH: imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC: imm32 = {ins[31:12], 12'b0};
            OPC_JAL:    imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            OPC_OP, OPC_FENCE: imm32 = '0;
            default:    legal = 1'b0;
        endcase
        r.opcode  = ins[6:0];
        r.rd      = ins[11:7];
        r.funct3  = ins[14:12];
        r.rs1     = ins[19:15];
        r.rs2     = ins[24:20];
        r.funct7  = ins[31:25];
        r.imm     = XLEN'($signed(imm32));
        r.illegal = !legal;
        r.use_rs1 = legal && !(ins[6:0] inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_FENCE});
        r.use_rs2 = ins[6:0] inside {OPC_BRANCH, OPC_STORE, OPC_OP};
        r.we_rd   = legal && !(ins[6:0] inside {OPC_BRANCH, OPC_STORE, OPC_FENCE}) && (ins[11:7] != 5'd0);
        return r;
    endfunction

    logic             valid_q, valid_d;
    logic [LANES-1:0] mask_q;
    logic [SEQ_W-1:0] seq_q;
    logic [SEQ_W-1:0] next_seq_q;
    lane_t            lanes_q [LANES];
    lane_t            lanes_d [LANES];
    logic             in_ready;
    logic             accept;

    // Flush masks readiness so a same-cycle bundle is dropped rather than loaded.
    assign in_ready     = !bus.flush && (!valid_q || bus.out_ready);
    assign bus.in_ready = in_ready;
    assign accept       = bus.in_valid && in_ready && (|bus.in_lane_valid);

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lanes_d[i] = '0;
            if (bus.in_lane_valid[i]) begin
                lanes_d[i]    = decode_lane(bus.in_instr[32*i +: 32]);
                lanes_d[i].pc = bus.in_pc + (XLEN'(i) << 2);
            end
        end
        valid_d = valid_q;
        if (bus.flush)
            valid_d = 1'b0;
        else if (accept)
            valid_d = 1'b1;
        else if (bus.out_ready)
            valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            mask_q     <= '0;
            seq_q      <= '0;
            next_seq_q <= '0;
            for (int i = 0; i < LANES; i++) lanes_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                mask_q     <= bus.in_lane_valid;
                seq_q      <= next_seq_q;
                next_seq_q <= next_seq_q + SEQ_W'(1);
                lanes_q    <= lanes_d;
            end
        end
    end

    assign bus.out_valid      = valid_q;
    assign bus.out_lane_valid = mask_q;
    assign bus.out_seq        = seq_q;

    for (genvar g = 0; g < LANES; g++) begin : g_out
        assign bus.out_opcode[7*g +: 7]     = lanes_q[g].opcode;
        assign bus.out_funct3[3*g +: 3]     = lanes_q[g].funct3;
        assign bus.out_funct7[7*g +: 7]     = lanes_q[g].funct7;
        assign bus.out_rs1[5*g +: 5]        = lanes_q[g].rs1;
        assign bus.out_rs2[5*g +: 5]        = lanes_q[g].rs2;
        assign bus.out_rd[5*g +: 5]         = lanes_q[g].rd;
        assign bus.out_imm[XLEN*g +: XLEN]  = lanes_q[g].imm;
        assign bus.out_pc[XLEN*g +: XLEN]   = lanes_q[g].pc;
        assign bus.out_use_rs1[g]           = lanes_q[g].use_rs1;
        assign bus.out_use_rs2[g]           = lanes_q[g].use_rs2;
        assign bus.out_we_rd[g]             = lanes_q[g].we_rd;
        assign bus.out_illegal[g]           = lanes_q[g].illegal;
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized scoreboard bench for decode_stage
module tb_decode_stage;
    localparam int L  = 2;
    localparam int X  = 32;
    localparam int S  = 8;
    localparam int LW = 7 + 3 + 7 + 5 + 5 + 5 + X + X + 4;
    localparam int OW = 1 + S + L + L * LW;
    typedef logic [OW-1:0]   obs_t;
    typedef logic [L*LW-1:0] lanes_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_stage_if #(.LANES(L), .XLEN(X), .SEQ_W(S)) bif ();
    decode_stage #(.LANES(L), .XLEN(X), .SEQ_W(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

    int n_cmp = 0;
    int n_bad = 0;

    logic         m_valid;
    logic [S-1:0] m_seq;
    logic [S-1:0] m_next;
    logic [L-1:0] m_mask;
    lanes_t       m_lanes;
    logic [6:0]   ops [11] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F};

    // Reference decode from the ISA encoding tables using plain integer arithmetic.
    function automatic logic [LW-1:0] ref_lane(input logic [31:0] ins, input logic lv, input logic [31:0] pc);
        longint      v;
        int          op, rd;
        bit          legal, u1, u2, we;
        logic [31:0] imm;
        if (!lv) return '0;
        op = int'(ins & 32'h7F);
        rd = int'((ins >> 7) & 32'h1F);
        legal = 1; v = 0;
        case (op)
            'h03, 'h13, 'h67, 'h73: begin v = longint'(ins >> 20); if (v >= 2048) v -= 4096; end
            'h23: begin v = longint'(((ins >> 25) << 5) | ((ins >> 7) & 31)); if (v >= 2048) v -= 4096; end
            'h63: begin
                v = longint'((((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11) |
                             (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1));
                if (v >= 4096) v -= 8192;
            end
            'h37, 'h17: v = longint'(ins & 32'hFFFFF000);
            'h6F: begin
                v = longint'((((ins >> 31) & 1) << 20) | (((ins >> 12) & 255) << 12) |
                             (((ins >> 20) & 1) << 11) | (((ins >> 21) & 1023) << 1));
                if (v >= (1 << 20)) v -= (1 << 21);
            end
            'h33, 'h0F: v = 0;
            default: legal = 0;
        endcase
        imm = v[31:0];
        u1 = legal && !(op == 'h37 || op == 'h17 || op == 'h6F || op == 'h0F);
        u2 = (op == 'h63 || op == 'h23 || op == 'h33);
        we = legal && !(op == 'h63 || op == 'h23 || op == 'h0F) && rd != 0;
        return {ins[6:0], ins[14:12], ins[31:25], ins[19:15], ins[24:20], ins[11:7], imm, pc, u1, u2, we, !legal};
    endfunction

    function automatic lanes_t ref_lanes(input logic [32*L-1:0] w, input logic [L-1:0] m, input logic [31:0] pc);
        lanes_t r = '0;
        for (int i = 0; i < L; i++) r = (r << LW) | lanes_t'(ref_lane(w[32*i +: 32], m[i], pc + 32'(4 * i)));
        return r;
    endfunction

    function automatic obs_t exp_obs();
        return {m_valid, m_seq, m_mask, m_lanes};
    endfunction

    function automatic obs_t dut_obs();
        lanes_t r = '0;
        for (int i = 0; i < L; i++)
            r = (r << LW) | lanes_t'({bif.out_opcode[7*i +: 7], bif.out_funct3[3*i +: 3], bif.out_funct7[7*i +: 7],
                                      bif.out_rs1[5*i +: 5], bif.out_rs2[5*i +: 5], bif.out_rd[5*i +: 5],
                                      bif.out_imm[X*i +: X], bif.out_pc[X*i +: X], bif.out_use_rs1[i],
                                      bif.out_use_rs2[i], bif.out_we_rd[i], bif.out_illegal[i]});
        return {bif.out_valid, bif.out_seq, bif.out_lane_valid, r};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins = $urandom;
        if ($urandom_range(0, 7) != 0) ins[6:0] = ops[$urandom_range(0, 10)];
        return ins;
    endfunction

    task automatic drive(input logic [32*L-1:0] w, input logic [L-1:0] m, input logic [31:0] pc,
                         input logic iv, input logic ordy, input logic fl);
        bif.in_instr = w; bif.in_lane_valid = m; bif.in_pc = pc;
        bif.in_valid = iv; bif.out_ready = ordy; bif.flush = fl;
        #1;
    endtask

    function automatic logic exp_ready();
        return !bif.flush && (!m_valid || bif.out_ready);
    endfunction

    // Advance one clock and apply the handshake rules to the model.
    task automatic tick();
        logic   acc;
        lanes_t nl;
        acc = bif.in_valid && exp_ready() && (bif.in_lane_valid != '0);
        nl  = ref_lanes(bif.in_instr, bif.in_lane_valid, bif.in_pc);
        @(posedge clk); #1;
        if (bif.flush) m_valid = 1'b0;
        else if (acc) begin
            m_valid = 1'b1; m_lanes = nl; m_mask = bif.in_lane_valid; m_seq = m_next; m_next = m_next + 1'b1;
        end else if (bif.out_ready) m_valid = 1'b0;
    endtask

    task automatic model_clear();
        m_valid = 0; m_seq = '0; m_next = '0; m_mask = '0; m_lanes = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive('0, '0, '0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_obs() !== obs_t'(0)) begin n_bad++; $display("FAIL reset_outputs got=%h exp=0", dut_obs()); end
        do_reset();
        n_cmp++;
        if (bif.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", bif.in_ready); end
        n_cmp++;
        if (dut_obs() !== exp_obs()) begin n_bad++; $display("FAIL reset_after_release got=%h exp=%h", dut_obs(), exp_obs()); end
    endtask

    task automatic test_directed();
        drive({32'h0020A423, 32'h00500093}, 2'b11, 32'h100, 1, 1, 0);
        tick();
        n_cmp++;
        if (dut_obs() !== exp_obs()) begin n_bad++; $display("FAIL addi_sw_bundle got=%h exp=%h", dut_obs(), exp_obs()); end
        n_cmp++;
        if ({bif.out_rd[4:0], bif.out_rs1[4:0], bif.out_imm[31:0], bif.out_we_rd[0], bif.out_pc[31:0]}
            !== {5'd1, 5'd0, 32'd5, 1'b1, 32'h100}) begin
            n_bad++; $display("FAIL addi_lane0 got rd=%0d rs1=%0d imm=%h we=%b pc=%h", bif.out_rd[4:0],
                              bif.out_rs1[4:0], bif.out_imm[31:0], bif.out_we_rd[0], bif.out_pc[31:0]);
        end
        n_cmp++;
        if ({bif.out_rs1[9:5], bif.out_rs2[9:5], bif.out_imm[63:32], bif.out_we_rd[1], bif.out_use_rs2[1], bif.out_pc[63:32]}
            !== {5'd1, 5'd2, 32'd8, 1'b0, 1'b1, 32'h104}) begin
            n_bad++; $display("FAIL sw_lane1 got rs1=%0d rs2=%0d imm=%h we=%b u2=%b pc=%h", bif.out_rs1[9:5],
                              bif.out_rs2[9:5], bif.out_imm[63:32], bif.out_we_rd[1], bif.out_use_rs2[1], bif.out_pc[63:32]);
        end
        drive({32'h123452B7, 32'hFE000EE3}, 2'b11, 32'h200, 1, 1, 0);
        tick();
        n_cmp++;
        if (dut_obs() !== exp_obs()) begin n_bad++; $display("FAIL beq_lui_bundle got=%h exp=%h", dut_obs(), exp_obs()); end
        n_cmp++;
        if ({bif.out_imm[31:0], bif.out_we_rd[0], bif.out_use_rs2[0], bif.out_rd[9:5], bif.out_imm[63:32], bif.out_use_rs1[1]}
            !== {32'hFFFFFFFC, 1'b0, 1'b1, 5'd5, 32'h12345000, 1'b0}) begin
            n_bad++; $display("FAIL beq_lui_fields got imm0=%h we0=%b u2_0=%b rd1=%0d imm1=%h u1_1=%b", bif.out_imm[31:0],
                              bif.out_we_rd[0], bif.out_use_rs2[0], bif.out_rd[9:5], bif.out_imm[63:32], bif.out_use_rs1[1]);
        end
    endtask

    task automatic test_illegal_mask();
        logic [S-1:0] s0;
        drive({32'h00500093, 32'h00000000}, 2'b01, 32'h300, 1, 1, 0);
        tick();
        n_cmp++;
        if ({bif.out_illegal[0], bif.out_use_rs1[0], bif.out_use_rs2[0], bif.out_we_rd[0]} !== 4'b1000) begin
            n_bad++; $display("FAIL illegal_flags got=%b exp=1000",
                              {bif.out_illegal[0], bif.out_use_rs1[0], bif.out_use_rs2[0], bif.out_we_rd[0]});
        end
        n_cmp++;
        if ({bif.out_opcode[13:7], bif.out_rd[9:5], bif.out_rs1[9:5], bif.out_imm[63:32], bif.out_pc[63:32],
             bif.out_illegal[1], bif.out_use_rs1[1], bif.out_we_rd[1]} !== '0) begin
            n_bad++; $display("FAIL masked_lane1 got op=%h rd=%0d imm=%h pc=%h", bif.out_opcode[13:7],
                              bif.out_rd[9:5], bif.out_imm[63:32], bif.out_pc[63:32]);
        end
        n_cmp++;
        if (dut_obs() !== exp_obs()) begin n_bad++; $display("FAIL illegal_bundle got=%h exp=%h", dut_obs(), exp_obs()); end
        s0 = bif.out_seq;
        drive({rand_instr(), rand_instr()}, 2'b00, $urandom, 1, 1, 0);
        tick();
        n_cmp++;
        if ({bif.out_valid, bif.out_seq} !== {1'b0, s0}) begin
            n_bad++; $display("FAIL empty_mask_ignored got v=%b seq=%0d exp v=0 seq=%0d", bif.out_valid, bif.out_seq, s0);
        end
    endtask

    task automatic test_stall();
        obs_t held;
        drive({rand_instr(), rand_instr()}, 2'b11, $urandom, 1, 1, 0);
        tick();
        held = dut_obs();
        drive({rand_instr(), rand_instr()}, 2'b11, $urandom, 1, 0, 0);
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (bif.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready c=%0d got=%b exp=0", c, bif.in_ready); end
            tick();
            n_cmp++;
            if (dut_obs() !== held || held !== exp_obs()) begin
                n_bad++; $display("FAIL stall_hold c=%0d got=%h exp=%h", c, dut_obs(), exp_obs());
            end
        end
        bif.out_ready = 1'b1; #1;
        n_cmp++;
        if (bif.in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready got=%b exp=1", bif.in_ready); end
        tick();
        n_cmp++;
        if (dut_obs() !== exp_obs() || bif.out_seq !== held[OW-2 -: S] + 1'b1) begin
            n_bad++; $display("FAIL stall_release got=%h exp=%h", dut_obs(), exp_obs());
        end
    endtask

    task automatic test_flush();
        logic [S-1:0] s0;
        drive({rand_instr(), rand_instr()}, 2'b11, $urandom, 1, 0, 0);
        tick();
        s0 = bif.out_seq;
        drive({rand_instr(), rand_instr()}, 2'b11, $urandom, 1, 0, 1);
        n_cmp++;
        if (bif.in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready got=%b exp=0", bif.in_ready); end
        tick();
        n_cmp++;
        if ({bif.out_valid, bif.out_seq} !== {1'b0, s0} || dut_obs() !== exp_obs()) begin
            n_bad++; $display("FAIL flush_clear got=%h exp=%h", dut_obs(), exp_obs());
        end
        bif.flush = 1'b0;
    endtask

    task automatic test_reset_midstall();
        drive({rand_instr(), rand_instr()}, 2'b11, $urandom, 1, 1, 0);
        tick();
        drive({rand_instr(), rand_instr()}, 2'b11, $urandom, 1, 0, 0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_obs() !== obs_t'(0)) begin n_bad++; $display("FAIL async_reset got=%h exp=0", dut_obs()); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
        drive({rand_instr(), rand_instr()}, 2'b10, $urandom, 1, 1, 0);
        tick();
        n_cmp++;
        if (bif.out_seq !== '0 || dut_obs() !== exp_obs()) begin
            n_bad++; $display("FAIL first_after_reset got=%h exp=%h", dut_obs(), exp_obs());
        end
    endtask

    task automatic test_seq_wrap();
        do_reset();
        for (int k = 0; k <= 256; k++) begin
            drive({rand_instr(), rand_instr()}, L'($urandom_range(1, 3)), $urandom, 1, 1, 0);
            tick();
            n_cmp++;
            if (bif.out_seq !== S'(k) || dut_obs() !== exp_obs()) begin
                n_bad++; $display("FAIL seq_wrap k=%0d got seq=%0d exp=%0d", k, bif.out_seq, S'(k));
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            drive({rand_instr(), rand_instr()}, L'($urandom_range(0, 3)),
                  ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFC : 32'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            n_cmp++;
            if (bif.in_ready !== exp_ready()) begin
                n_bad++; $display("FAIL rand_in_ready c=%0d got=%b exp=%b", c, bif.in_ready, exp_ready());
            end
            tick();
            n_cmp++;
            if (dut_obs() !== exp_obs()) begin
                n_bad++; $display("FAIL rand_bundle c=%0d got=%h exp=%h", c, dut_obs(), exp_obs());
            end
        end
    endtask

    initial begin
        model_clear();
        bif.flush = 0; bif.in_valid = 0; bif.out_ready = 0;
        bif.in_instr = '0; bif.in_lane_valid = '0; bif.in_pc = '0;
        test_reset();
        test_directed();
        test_illegal_mask();
        test_stall();
        test_flush();
        test_reset_midstall();
        test_seq_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
